// File: rtl/keyscan_enc_if.sv
// Press-event handshake between the key scanner (master) and its consumer (slave).
// The master presents ev_val while ev_valid is high; the consumer pops with ev_ready.
interface keyscan_enc_if #(
  parameter int VW = 4
) ();
  logic          ev_valid;
  logic [VW-1:0] ev_val;
  logic          ev_ready;

  modport master (output ev_valid, output ev_val, input ev_ready);
  modport slave  (input ev_valid, input ev_val, output ev_ready);
endinterface

// File: rtl/keyscan_enc.sv
// Key matrix front end: synchronizes and debounces raw key levels as one vector,
// reports the lowest pressed key, and queues one event per new press in a small FIFO.
module keyscan_enc #(
  parameter int NKEYS      = 16,
  parameter int VW         = 4,
  parameter int DB_CYCLES  = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys,
  output logic             key_in,
  output logic [VW-1:0]    key_val,
  keyscan_enc_if.master    ev,
  output logic [VW:0]      ev_count,
  output logic             overflow
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  function automatic logic [VW-1:0] lowest_idx(input logic [NKEYS-1:0] v);
    lowest_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = VW'(i);
    end
  endfunction

  logic [NKEYS-1:0] sync_meta, sync_q;
  logic [NKEYS-1:0] stable, stable_d;
  logic [CW-1:0]    db_cnt;
  logic [VW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [NW-1:0]    count;

  logic [NKEYS-1:0] newly;
  logic             push, pop, full, do_push;

  // Events come from the registered edge of stable, so a press enters the queue
  // one cycle after the debounced level changes and never bypasses it.
  always_comb begin
    newly   = stable & ~stable_d;
    push    = |newly;
    full    = (count == NW'(FIFO_DEPTH));
    pop     = ev.ev_valid & ev.ev_ready;
    do_push = push & (~full | pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
      stable    <= '0;
      stable_d  <= '0;
      db_cnt    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      sync_meta <= keys;
      sync_q    <= sync_meta;
      stable_d  <= stable;

      // Whole-vector debounce: only a return to stable restarts the count.
      if (sync_q != stable) begin
        if (db_cnt == CW'(DB_CYCLES - 1)) begin
          stable <= sync_q;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end else begin
        db_cnt <= '0;
      end

      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase

      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are live, and ev_val is forced to 0 while the queue is empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= lowest_idx(newly);
  end

  assign key_in      = |stable;
  assign key_val     = lowest_idx(stable);
  assign ev.ev_valid = (count != '0);
  assign ev.ev_val   = ev.ev_valid ? mem[rd_ptr] : '0;
  assign ev_count    = (VW + 1)'(count);

endmodule

// File: doc/keyscan_enc.md
KEYSCAN_ENC -- requirements
Module: keyscan_enc

Interface
REQ-001 Parameter NKEYS, default 16: number of key inputs; legal range 2..64.
REQ-002 Parameter VW, default 4: key index width; SHALL equal ceil(log2(NKEYS)).
REQ-003 Parameter DB_CYCLES, default 1000: debounce settle time in clock cycles; minimum 2.
REQ-004 Parameter FIFO_DEPTH, default 4: press-event queue depth; power of two, minimum 2.
REQ-005 clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 keys  input  NKEYS  raw key levels, asynchronous to clock, bouncy; 1 = pressed.
REQ-008 key_in  output  1  1 while any debounced key is pressed.
REQ-009 key_val  output  VW  index of the lowest-numbered debounced pressed key.
REQ-010 ev_valid  output  1  press-event queue is non-empty.
REQ-011 ev_val  output  VW  key index at the head of the queue.
REQ-012 ev_ready  input  1  consumer accepts the head event.
REQ-013 ev_count  output  VW+1  number of queued events, 0..FIFO_DEPTH.
REQ-014 overflow  output  1  sticky flag: an event was dropped because the queue was full.

Function
REQ-015 keys SHALL pass through a 2-flop synchronizer (sync) before any other use.
REQ-016 A debounced register stable[NKEYS-1:0] and a settle counter SHALL be maintained.
REQ-017 Counter behaviour: sync != stable -> counter increments; sync == stable -> counter clears to 0.
REQ-018 When sync != stable and the counter equals DB_CYCLES-1, stable SHALL load sync and the counter SHALL clear.
REQ-019 Any glitch shorter than DB_CYCLES cycles at sync (sync returns to stable) SHALL leave stable unchanged.
REQ-020 Any change of sync while counting restarts the count only if sync returns to stable; a change between two values both differing from stable does not restart the count (whole-vector debounce).
REQ-021 key_in SHALL equal OR of stable.
REQ-022 key_val SHALL be the lowest set bit index of stable, and 0 when stable is all zero.
REQ-023 On each stable load, newly = new & ~old; if newly != 0, one event carrying the lowest set index of newly SHALL be pushed.
REQ-024 Releases SHALL NOT generate events.
REQ-025 Several keys pressed in one stable load SHALL produce exactly one event (lowest index).
REQ-026 Latency: keys steady from edge t (after bouncing) -> stable updated at edge t+2+DB_CYCLES -> ev_valid high in the cycle after that edge.
REQ-027 Queue is a FIFO: in-order delivery; ev_val SHALL be valid whenever ev_valid = 1, and 0 when the queue is empty.
REQ-028 Pop occurs on an edge where ev_valid & ev_ready; ev_ready while empty SHALL have no effect.
REQ-029 Push while full without a simultaneous pop: event dropped, overflow set to 1, queue contents unchanged.
REQ-030 Push and pop on the same edge while full: both SHALL take effect; no drop; ev_count unchanged.
REQ-031 Push and pop on the same edge while non-full, non-empty: ev_count unchanged.
REQ-032 Push while empty with ev_ready = 1: the event SHALL enter the queue; it SHALL NOT bypass it (ev_valid rises one cycle later).
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 overflow SHALL be cleared only by reset.

Reset
REQ-035 On reset: sync, stable, counter and pointers cleared; ev_count = 0; ev_valid = 0; ev_val = 0; key_in = 0; key_val = 0; overflow = 0.
REQ-036 Reset SHALL take priority over every other event on the same edge.
REQ-037 Reset asserted mid-debounce or with a non-empty queue SHALL discard all pending state.
REQ-038 Keys held through reset release SHALL be debounced afresh and SHALL generate a press event DB_CYCLES+2 cycles after release.

Verification (DB_CYCLES=4, FIFO_DEPTH=4, NKEYS=16)
REQ-039 Clean press: keys=0x0020 held from edge t -> key_in=1, key_val=5 after edge t+6; ev_valid=1, ev_val=5 from t+7; pop with ev_ready -> ev_count=0.
REQ-040 Bounce: keys toggles 0x0001/0x0000 every 2 cycles for 20 cycles, then 0 -> no stable change, no event, key_in stays 0.
REQ-041 Multi-press: keys 0 -> 0x8104 in one step -> key_val=2, exactly one event with ev_val=2; then add bit 0 -> event 0, key_val=0; release all -> key_in=0, no event.
REQ-042 Overflow: 5 distinct debounced presses (keys 1,3,7,9,11), ev_ready=0 -> ev_count=4, overflow=1; drain -> ev_val sequence 1,3,7,9.
REQ-043 Full with simultaneous push/pop: queue full, ev_ready=1 on the push edge -> no drop, overflow stays 0, ev_count stays 4.
REQ-044 Reset mid-operation: reset during counting with 2 queued events -> all outputs 0 on the next cycle; key held -> new event 6 cycles after reset release.
